memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter sharing the single-ported unified memory between the RISC-V core (port 0) and an external debug/loader port (port 1) inside the Tiny Tapeout top level. Each cycle it grants at most one requester, drives that requester's address, write data and byte enables to the memory, and returns read data to the same requester one cycle later with a valid strobe. Arbitration is round-robin with an optional bounded lock for multi-word bursts.

## Interface
- ADDR_WIDTH, 32, address width (matches addr_t)
- DATA_WIDTH, 32, data width (matches data_t); byte enables are DATA_WIDTH/8 = 4 bits
- MAX_LOCK, 8, max consecutive grants a locking requester may hold (1..255)

- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pN_req  in  1  port N (N = 0,1) requests an access this cycle
- pN_lock  in  1  port N asks to keep the grant next cycle
- pN_address  in  ADDR_WIDTH  access address
- pN_write_data  in  DATA_WIDTH  store data
- pN_write_enable  in  4  byte enables; 0 = read
- pN_gnt  out  1  access accepted this cycle (combinational)
- pN_rvalid  out  1  pN_read_data valid (registered)
- pN_read_data  out  DATA_WIDTH  memory read data, forwarded
- memory__address  out  ADDR_WIDTH  to memory
- memory__write_data  out  DATA_WIDTH  to memory
- memory__write_enable  out  4  to memory
- memory__read_data  in  DATA_WIDTH  from memory, valid one cycle after address

## Operation
- State: last_gnt (1 bit, port granted most recently), owner_valid, lock_cnt (8 bits), rd_port (1 bit) + rd_pending (1 bit), addr_hold (ADDR_WIDTH).
- Grant: only one req -> grant it. Both req -> if lock active (owner_valid, owner's lock was high in its granted cycle, lock_cnt < MAX_LOCK, owner still requesting) grant owner; else grant port != last_gnt.
- lock_cnt: reset to 1 on a grant to a new port or a grant without lock; incremented on each consecutive locked grant to same port; at MAX_LOCK the lock is ignored for one arbitration, the other port (if requesting) wins, counter restarts.
- Lock with other port idle: owner keeps winning; lock_cnt saturates at MAX_LOCK, no effect until contention.
- Memory drive: granted port's address/write_data/write_enable passed through combinationally. No grant -> memory__write_enable = 0, memory__address = addr_hold (last granted address), memory__write_data = 0.
- Read return: every granted access with write_enable == 0 sets rd_pending=1, rd_port=granted port for next cycle; pN_rvalid = rd_pending && rd_port == N; both pN_read_data = memory__read_data. Writes produce no rvalid.
- Requesters hold req/address/data stable until gnt; a request may be withdrawn before gnt.
- pN_gnt never asserted when pN_req low; never both high.

## Timing
- Reset (synchronous, takes effect on edge with reset high): last_gnt = 1 (so port 0 wins first contention), owner_valid = 0, lock_cnt = 0, rd_pending = 0, addr_hold = 0. While reset high: both gnt = 0, memory__write_enable = 0, memory__address = 0, both rvalid = 0.
- Reset mid-read: pending rvalid cleared; no rvalid issued after reset.
- Grant latency: 0 cycles (gnt same cycle as req when won). Read latency: rvalid exactly 1 cycle after the granted read cycle.
- Back-to-back: a port may be granted every cycle; reads pipeline at 1/cycle, rvalid in order.
- Contention without lock: strict alternation 0,1,0,1...
- Simultaneous rvalid for the previous read and a new grant in the same cycle is legal.

## Test plan
- Reset: hold reset 3 cycles with p0_req=p1_req=1, write_enable=4'hF -> gnt both 0, memory__write_enable=0, rvalid 0; release -> first cycle grants p0.
- Single-port read/write: p0 writes 32'hDEADBEEF to 0x10 (we=4'hF), then reads 0x10 -> p0_gnt both cycles, p0_rvalid one cycle after read with data 32'hDEADBEEF, p1_rvalid stays 0.
- Contention: both request reads continuously for 6 cycles -> grants p0,p1,p0,p1,p0,p1; rvalid tags follow same order 1 cycle later.
- Lock bound: MAX_LOCK=4, p1 req+lock continuous after winning, p0 req continuous -> p1 granted 4 consecutive cycles, then p0 once, then p1 again.
- Byte write: p1 writes 32'h000000AA with we=4'b0001 over 0x11223344 at 0x20, read back -> 32'h112233AA.
- Idle/reset mid-read: p0 read granted, reset asserted next edge -> no p0_rvalid; with no requests memory__address holds last granted address and write_enable = 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between the core (port 0)
// and the debug/loader port (port 1). Round-robin arbitration with a bounded
// lock for bursts, combinational request forwarding to the memory, and a
// registered read-return strobe one cycle after each granted read.
module memory_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 8
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    p0_req,
   input  logic                    p0_lock,
   input  logic [ADDR_WIDTH-1:0]   p0_address,
   input  logic [DATA_WIDTH-1:0]   p0_write_data,
   input  logic [DATA_WIDTH/8-1:0] p0_write_enable,
   output logic                    p0_gnt,
   output logic                    p0_rvalid,
   output logic [DATA_WIDTH-1:0]   p0_read_data,

   input  logic                    p1_req,
   input  logic                    p1_lock,
   input  logic [ADDR_WIDTH-1:0]   p1_address,
   input  logic [DATA_WIDTH-1:0]   p1_write_data,
   input  logic [DATA_WIDTH/8-1:0] p1_write_enable,
   output logic                    p1_gnt,
   output logic                    p1_rvalid,
   output logic [DATA_WIDTH-1:0]   p1_read_data,

   output logic [ADDR_WIDTH-1:0]   memory__address,
   output logic [DATA_WIDTH-1:0]   memory__write_data,
   output logic [DATA_WIDTH/8-1:0] memory__write_enable,
   input  logic [DATA_WIDTH-1:0]   memory__read_data
);

   localparam int              BE_WIDTH   = DATA_WIDTH / 8;
   localparam logic [7:0]      MAX_LOCK_C = 8'(MAX_LOCK);

   // Arbitration state
   logic                  last_gnt_q,    last_gnt_d;     // port granted most recently
   logic                  owner_valid_q, owner_valid_d;  // previous cycle carried a grant
   logic                  owner_lock_q,  owner_lock_d;   // that grant asked to keep the bus
   logic [7:0]            lock_cnt_q,    lock_cnt_d;     // consecutive locked grants so far
   // Read-return state
   logic                  rd_pending_q,  rd_pending_d;
   logic                  rd_port_q,     rd_port_d;
   // Address parked on the memory while idle
   logic [ADDR_WIDTH-1:0] addr_hold_q,   addr_hold_d;

   // Combinational arbitration results
   logic                  owner_req_s;
   logic                  lock_active_s;
   logic                  gnt_valid_s;
   logic                  gnt_port_s;
   logic                  sel_lock_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_wdata_s;
   logic [BE_WIDTH-1:0]   sel_we_s;
   logic                  continue_lock_s;

   // Decide whether the previous owner's lock still holds this cycle
   always_comb begin
      owner_req_s   = 1'b0;
      lock_active_s = 1'b0;
      if (last_gnt_q == 1'b1) begin
         owner_req_s = p1_req;
      end else begin
         owner_req_s = p0_req;
      end
      lock_active_s = owner_valid_q & owner_lock_q & (lock_cnt_q < MAX_LOCK_C) & owner_req_s;
   end

   // Pick the winner: single requester wins, contention goes to the lock owner or round-robin
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_port_s  = 1'b0;
      if (reset) begin
         gnt_valid_s = 1'b0;
         gnt_port_s  = 1'b0;
      end else if (p0_req && p1_req) begin
         gnt_valid_s = 1'b1;
         if (lock_active_s) begin
            gnt_port_s = last_gnt_q;
         end else begin
            gnt_port_s = ~last_gnt_q;
         end
      end else if (p0_req) begin
         gnt_valid_s = 1'b1;
         gnt_port_s  = 1'b0;
      end else if (p1_req) begin
         gnt_valid_s = 1'b1;
         gnt_port_s  = 1'b1;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_port_s  = 1'b0;
      end
   end

   // Select the winning port's access fields
   always_comb begin
      sel_lock_s  = 1'b0;
      sel_addr_s  = '0;
      sel_wdata_s = '0;
      sel_we_s    = '0;
      case (gnt_port_s)
         1'b0: begin
            sel_lock_s  = p0_lock;
            sel_addr_s  = p0_address;
            sel_wdata_s = p0_write_data;
            sel_we_s    = p0_write_enable;
         end
         1'b1: begin
            sel_lock_s  = p1_lock;
            sel_addr_s  = p1_address;
            sel_wdata_s = p1_write_data;
            sel_we_s    = p1_write_enable;
         end
         default: begin
            sel_lock_s  = 1'b0;
            sel_addr_s  = '0;
            sel_wdata_s = '0;
            sel_we_s    = '0;
         end
      endcase
   end

   // Drive the memory: pass-through on grant, parked and harmless otherwise
   always_comb begin
      memory__address      = '0;
      memory__write_data   = '0;
      memory__write_enable = '0;
      if (gnt_valid_s) begin
         memory__address      = sel_addr_s;
         memory__write_data   = sel_wdata_s;
         memory__write_enable = sel_we_s;
      end else if (reset) begin
         memory__address      = '0;
         memory__write_data   = '0;
         memory__write_enable = '0;
      end else begin
         memory__address      = addr_hold_q;
         memory__write_data   = '0;
         memory__write_enable = '0;
      end
   end

   // Compute next arbitration, lock-count and read-return state
   always_comb begin
      last_gnt_d      = last_gnt_q;
      owner_valid_d   = 1'b0;
      owner_lock_d    = 1'b0;
      lock_cnt_d      = lock_cnt_q;
      addr_hold_d     = addr_hold_q;
      rd_pending_d    = 1'b0;
      rd_port_d       = rd_port_q;
      // A grant extends the count only when the same port keeps a lock it already held
      continue_lock_s = owner_valid_q & owner_lock_q & sel_lock_s & (gnt_port_s == last_gnt_q);
      if (gnt_valid_s) begin
         last_gnt_d    = gnt_port_s;
         owner_valid_d = 1'b1;
         owner_lock_d  = sel_lock_s;
         addr_hold_d   = sel_addr_s;
         rd_pending_d  = (sel_we_s == {BE_WIDTH{1'b0}});
         rd_port_d     = gnt_port_s;
         if (continue_lock_s) begin
            // Saturate once the bound is hit; contention then hands the bus over
            if (lock_cnt_q < MAX_LOCK_C) begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end else begin
               lock_cnt_d = lock_cnt_q;
            end
         end else begin
            lock_cnt_d = 8'd1;
         end
      end else begin
         last_gnt_d    = last_gnt_q;
         owner_valid_d = 1'b0;
         owner_lock_d  = 1'b0;
         lock_cnt_d    = lock_cnt_q;
         addr_hold_d   = addr_hold_q;
         rd_pending_d  = 1'b0;
         rd_port_d     = rd_port_q;
      end
   end

   // State registers; reset makes port 0 win the first contention
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q    <= 1'b1;
         owner_valid_q <= 1'b0;
         owner_lock_q  <= 1'b0;
         lock_cnt_q    <= 8'd0;
         rd_pending_q  <= 1'b0;
         rd_port_q     <= 1'b0;
         addr_hold_q   <= '0;
      end else begin
         last_gnt_q    <= last_gnt_d;
         owner_valid_q <= owner_valid_d;
         owner_lock_q  <= owner_lock_d;
         lock_cnt_q    <= lock_cnt_d;
         rd_pending_q  <= rd_pending_d;
         rd_port_q     <= rd_port_d;
         addr_hold_q   <= addr_hold_d;
      end
   end

   // Grants are exclusive; rvalid is the registered read tag, silenced during reset
   assign p0_gnt       = gnt_valid_s & ~gnt_port_s;
   assign p1_gnt       = gnt_valid_s &  gnt_port_s;
   assign p0_rvalid    = rd_pending_q & ~rd_port_q & ~reset;
   assign p1_rvalid    = rd_pending_q &  rd_port_q & ~reset;
   assign p0_read_data = memory__read_data;
   assign p1_read_data = memory__read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_memory_arbiter;

   localparam int MAX_LOCK = 4;

   typedef struct packed {
      logic        req;
      logic        lock;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  we;
   } req_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_lock, p0_gnt, p0_rvalid;
   logic [31:0] p0_address, p0_write_data, p0_read_data;
   logic [3:0]  p0_write_enable;
   logic        p1_req, p1_lock, p1_gnt, p1_rvalid;
   logic [31:0] p1_address, p1_write_data, p1_read_data;
   logic [3:0]  p1_write_enable;
   logic [31:0] memory__address, memory__write_data, memory__read_data;
   logic [3:0]  memory__write_enable;

   int n_total = 0;
   int n_bad   = 0;

   // Memory attached to the DUT
   logic [31:0] tb_mem [256];
   logic        mem_clear;

   // Reference model state
   logic [31:0] ref_mem [256];
   int          m_last;
   logic        m_prev_valid;
   int          m_prev_port;
   logic        m_prev_lock;
   int          m_run;
   logic        m_pend_valid;
   int          m_pend_port;
   logic [31:0] m_pend_data;
   logic [31:0] m_hold;

   memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_lock(p0_lock), .p0_address(p0_address),
      .p0_write_data(p0_write_data), .p0_write_enable(p0_write_enable),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_read_data(p0_read_data),
      .p1_req(p1_req), .p1_lock(p1_lock), .p1_address(p1_address),
      .p1_write_data(p1_write_data), .p1_write_enable(p1_write_enable),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_read_data(p1_read_data),
      .memory__address(memory__address), .memory__write_data(memory__write_data),
      .memory__write_enable(memory__write_enable), .memory__read_data(memory__read_data)
   );

   always #5 clk = ~clk;

   // Single-ported byte-enabled memory with one-cycle read latency
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (memory__write_enable[k])
               tb_mem[memory__address[7:0]][8*k +: 8] <= memory__write_data[8*k +: 8];
      end
      memory__read_data <= tb_mem[memory__address[7:0]];
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic req_t mk(input logic rq, input logic lk, input logic [31:0] ad,
                               input logic [31:0] wd, input logic [3:0] we);
      req_t r;
      r.req = rq; r.lock = lk; r.addr = ad; r.wd = wd; r.we = we;
      return r;
   endfunction

   // One clock cycle: drive, predict, compare, then advance the model past the edge
   task automatic step(input logic rst, input req_t a, input req_t b,
                       output logic g0, output logic g1);
      int          win;
      logic        hold_ok;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_we;
      logic        e_rv0, e_rv1;
      req_t        c;
      int          idx;
      reset = rst;
      p0_req = a.req; p0_lock = a.lock; p0_address = a.addr; p0_write_data = a.wd; p0_write_enable = a.we;
      p1_req = b.req; p1_lock = b.lock; p1_address = b.addr; p1_write_data = b.wd; p1_write_enable = b.we;
      #1;
      win = -1;
      hold_ok = 1'b0;
      if (!rst) begin
         hold_ok = m_prev_valid && m_prev_lock && (m_run < MAX_LOCK) &&
                   ((m_prev_port == 0) ? a.req : b.req);
         if (a.req && b.req) win = hold_ok ? m_prev_port : ((m_last == 1) ? 0 : 1);
         else if (a.req) win = 0;
         else if (b.req) win = 1;
      end
      c = (win == 1) ? b : a;
      e_addr = (win >= 0) ? c.addr : (rst ? 32'h0 : m_hold);
      e_wd   = (win >= 0) ? c.wd : 32'h0;
      e_we   = (win >= 0) ? c.we : 4'h0;
      e_rv0  = !rst && m_pend_valid && (m_pend_port == 0);
      e_rv1  = !rst && m_pend_valid && (m_pend_port == 1);
      check_val("p0_gnt", 64'(p0_gnt), 64'(win == 0));
      check_val("p1_gnt", 64'(p1_gnt), 64'(win == 1));
      check_val("mem_addr", 64'(memory__address), 64'(e_addr));
      check_val("mem_wdata", 64'(memory__write_data), 64'(e_wd));
      check_val("mem_we", 64'(memory__write_enable), 64'(e_we));
      check_val("p0_rvalid", 64'(p0_rvalid), 64'(e_rv0));
      check_val("p1_rvalid", 64'(p1_rvalid), 64'(e_rv1));
      if (e_rv0) check_val("p0_rdata", 64'(p0_read_data), 64'(m_pend_data));
      if (e_rv1) check_val("p1_rdata", 64'(p1_read_data), 64'(m_pend_data));
      g0 = p0_gnt;
      g1 = p1_gnt;
      @(posedge clk);
      if (rst) begin
         m_last = 1; m_prev_valid = 1'b0; m_prev_lock = 1'b0; m_run = 0;
         m_pend_valid = 1'b0; m_hold = 32'h0;
      end else if (win >= 0) begin
         if (c.lock)
            m_run = (m_prev_valid && m_prev_port == win && m_prev_lock) ? m_run + 1 : 1;
         else
            m_run = 0;
         m_prev_valid = 1'b1; m_prev_port = win; m_prev_lock = c.lock; m_last = win;
         m_hold = c.addr;
         idx = int'(c.addr[7:0]);
         m_pend_valid = (c.we == 4'h0); m_pend_port = win; m_pend_data = ref_mem[idx];
         for (int k = 0; k < 4; k++)
            if (c.we[k]) ref_mem[idx][8*k +: 8] = c.wd[8*k +: 8];
      end else begin
         m_prev_valid = 1'b0; m_prev_lock = 1'b0; m_pend_valid = 1'b0;
      end
      #1;
   endtask

   initial begin
      req_t        idle, ra, rb, pa, pb;
      logic        g0, g1;
      logic [5:0]  pat;
      logic        rst_r;
      idle = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      m_last = 1; m_prev_valid = 1'b0; m_prev_port = 0; m_prev_lock = 1'b0; m_run = 0;
      m_pend_valid = 1'b0; m_pend_port = 0; m_pend_data = 32'h0; m_hold = 32'h0;
      mem_clear = 1'b1;
      reset = 1'b1;
      p0_req = 1'b0; p0_lock = 1'b0; p0_address = 32'h0; p0_write_data = 32'h0; p0_write_enable = 4'h0;
      p1_req = 1'b0; p1_lock = 1'b0; p1_address = 32'h0; p1_write_data = 32'h0; p1_write_enable = 4'h0;
      @(posedge clk); #1;

      // Reset held with both ports requesting full writes
      ra = mk(1'b1, 1'b0, 32'h8, 32'hA5A5A5A5, 4'hF);
      rb = mk(1'b1, 1'b0, 32'hC, 32'h5A5A5A5A, 4'hF);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, ra, rb, g0, g1);
         check_val("rst_gnt", 64'({g0, g1}), 64'(2'b00));
      end
      mem_clear = 1'b0;
      step(1'b0, ra, rb, g0, g1);
      check_val("first_gnt_p0", 64'({g0, g1}), 64'(2'b10));

      // Single-port write then read-back
      step(1'b0, mk(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF), idle, g0, g1);
      step(1'b0, mk(1'b1, 1'b0, 32'h10, 32'h0, 4'h0), idle, g0, g1);
      check_val("rd_gnt_p0", 64'(g0), 64'(1'b1));
      check_val("rd_rvalid_p0", 64'(p0_rvalid), 64'(1'b1));
      check_val("rd_rvalid_p1", 64'(p1_rvalid), 64'(1'b0));
      check_val("rd_data", 64'(p0_read_data), 64'(32'hDEADBEEF));
      step(1'b0, idle, idle, g0, g1);

      // Contention without lock alternates starting with port 0
      step(1'b0, idle, mk(1'b1, 1'b0, 32'h14, 32'h0, 4'h0), g0, g1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, mk(1'b1, 1'b0, 32'h10, 32'h0, 4'h0), mk(1'b1, 1'b0, 32'h14, 32'h0, 4'h0), g0, g1);
         pat[i] = g0;
      end
      check_val("alternate", 64'(pat), 64'(6'b010101));

      // Bounded lock: port 1 keeps 4 grants, yields once, then wins again
      step(1'b0, idle, mk(1'b1, 1'b1, 32'h18, 32'h0, 4'h0), g0, g1);
      pat[0] = g1;
      for (int i = 1; i < 6; i++) begin
         step(1'b0, mk(1'b1, 1'b0, 32'h10, 32'h0, 4'h0), mk(1'b1, 1'b1, 32'h18, 32'h0, 4'h0), g0, g1);
         pat[i] = g1;
      end
      check_val("lock_bound", 64'(pat), 64'(6'b101111));

      // Byte-enable write merges into existing word
      step(1'b0, idle, mk(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF), g0, g1);
      step(1'b0, idle, mk(1'b1, 1'b0, 32'h20, 32'h000000AA, 4'b0001), g0, g1);
      step(1'b0, idle, mk(1'b1, 1'b0, 32'h20, 32'h0, 4'h0), g0, g1);
      check_val("byte_rvalid", 64'(p1_rvalid), 64'(1'b1));
      check_val("byte_data", 64'(p1_read_data), 64'(32'h112233AA));
      step(1'b0, idle, idle, g0, g1);

      // Reset right after a granted read suppresses its rvalid
      step(1'b0, mk(1'b1, 1'b0, 32'h30, 32'h0, 4'h0), idle, g0, g1);
      step(1'b1, idle, idle, g0, g1);
      check_val("midrst_rvalid", 64'(p0_rvalid), 64'(1'b0));
      step(1'b0, idle, idle, g0, g1);
      step(1'b0, idle, mk(1'b1, 1'b0, 32'h44, 32'h12345678, 4'hF), g0, g1);
      step(1'b0, idle, idle, g0, g1);
      check_val("idle_addr", 64'(memory__address), 64'(32'h44));
      check_val("idle_we", 64'(memory__write_enable), 64'(4'h0));

      // Random traffic with held requests, withdrawals, locks and rare resets
      pa = idle; pb = idle;
      for (int n = 0; n < 600; n++) begin
         if (!pa.req && ($urandom % 3 != 0))
            pa = mk(1'b1, 1'b0, 32'($urandom_range(0, 63)), $urandom,
                    ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16));
         if (!pb.req && ($urandom % 3 != 0))
            pb = mk(1'b1, 1'b0, 32'($urandom_range(0, 63)), $urandom,
                    ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16));
         if ($urandom % 25 == 0) pa.req = 1'b0;
         if ($urandom % 25 == 0) pb.req = 1'b0;
         pa.lock = ($urandom % 4 != 0);
         pb.lock = ($urandom % 4 != 0);
         rst_r = ($urandom % 80 == 0);
         step(rst_r, pa, pb, g0, g1);
         if (g0) pa.req = 1'b0;
         if (g1) pb.req = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
